// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit: multi-cycle byte/half/word load-store initiator with
// read-modify-write for sub-word stores. Revision 1.0
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int MEM_BYTES_LOG2 = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] dm_address,
  output logic [31:0] dm_data_in,
  output logic        dm_mem_write,
  input  logic [31:0] dm_data_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        w_misaligned;
  logic        w_out_of_range;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  // Request checks use the live inputs: they are only acted on in IDLE.
  assign w_misaligned   = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
  assign w_out_of_range = |addr[31:MEM_BYTES_LOG2];

  assign w_byte = dm_data_out[{addr_q[1:0], 3'b000} +: 8];
  assign w_half = addr_q[1] ? dm_data_out[31:16] : dm_data_out[15:0];

  always_comb begin
    w_load = dm_data_out;
    case (size_q)
      2'b00:   w_load = {{24{sext_q & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{sext_q & w_half[15]}}, w_half};
      default: w_load = dm_data_out;
    endcase
  end

  always_comb begin
    w_merged = old_q;
    case (size_q)
      2'b00: w_merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) w_merged[31:16] = wdata_q[15:0];
        else           w_merged[15:0]  = wdata_q[15:0];
      end
      default: w_merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = w_misaligned | w_out_of_range;
          if (w_misaligned | w_out_of_range) state_d = S_DONE;
          else if (!we)                      state_d = S_READ;
          else if (size[1])                  state_d = S_WRITE;
          else                               state_d = S_READ;
        end
      end
      S_READ: begin
        // Sub-word stores reuse READ to fetch the word being patched.
        if (we_q) begin
          old_d   = dm_data_out;
          state_d = S_WRITE;
        end else begin
          rdata_d = w_load;
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      old_q   <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_DONE) & err_q;
  assign rdata        = rdata_q;
  assign dm_address   = {addr_q[31:2], 2'b00};
  assign dm_data_in   = w_merged;
  assign dm_mem_write = (state_q == S_WRITE) & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit: randomized scoreboard bench with a byte-level memory
// reference model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err;
  logic [31:0] rdata, dm_address, dm_data_in, dm_data_out;
  logic        dm_mem_write;

  mem_access_unit #(.MEM_BYTES_LOG2(12)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .err(err), .rdata(rdata), .dm_address(dm_address), .dm_data_in(dm_data_in),
    .dm_mem_write(dm_mem_write), .dm_data_out(dm_data_out)
  );

  always #5 clock = ~clock;

  // Data memory: combinational read, write on the clock edge.
  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = 10'd0;
  logic [31:0] pl_data = 32'd0;
  always @(posedge clock) begin
    if (pl_en)             mem[pl_idx] <= pl_data;
    else if (dm_mem_write) mem[dm_address[11:2]] <= dm_data_in;
  end
  assign dm_data_out = mem[dm_address[11:2]];

  // Reference model state
  logic [7:0]  ref_mem [0:4095];
  logic [31:0] ref_rdata = 32'd0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nwr;
    bit          chk_mem;
    int          widx;
    logic [31:0] mword;
  } exp_t;
  exp_t sb_q[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] ref_word(input int widx);
    return {ref_mem[widx*4+3], ref_mem[widx*4+2], ref_mem[widx*4+1], ref_mem[widx*4]};
  endfunction

  // Issue one request: compute the expected outcome, push it, then drive
  // req until done is observed. keep=1 leaves req high afterwards.
  task automatic issue(input logic iwe, input logic [1:0] isize, input logic isext,
                       input logic [31:0] iaddr, input logic [31:0] iwdata, input bit keep);
    exp_t e;
    int n;
    bit bad;
    logic [31:0] v;
    bit seen;
    n   = (isize == 2'b00) ? 1 : (isize == 2'b01) ? 2 : 4;
    bad = ((iaddr % n) != 0) || (iaddr >= 32'd4096);
    e.err = bad; e.nwr = 0; e.chk_mem = 0; e.widx = 0; e.mword = 0;
    if (bad) begin
      e.lat = 1;
    end else if (!iwe) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[iaddr + i];
      if (isext && n < 4 && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
      ref_rdata = v;
      e.lat = 2;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[iaddr + i] = iwdata[8*i +: 8];
      e.lat = (n == 4) ? 2 : 3;
      e.nwr = 1;
      e.chk_mem = 1;
      e.widx = int'(iaddr >> 2);
      e.mword = ref_word(e.widx);
    end
    e.rdata = ref_rdata;
    sb_q.push_back(e);
    we = iwe; size = isize; sign_ext = isext; addr = iaddr; wdata = iwdata; req = 1'b1;
    seen = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clock);
      seen = done;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done, expected done within 12 cycles");
    end
    if (!keep) req = 1'b0;
  endtask

  // Monitor: counts busy cycles and write strobes per transfer, checks at done.
  initial begin
    int cnt = 0;
    int wcnt = 0;
    bit gap = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (gap) begin
        check("idle_gap", {30'd0, busy, done}, 32'd0);
        gap = 0;
      end
      if (!busy) begin
        cnt = 0; wcnt = 0;
      end else begin
        cnt++;
        if (dm_mem_write) wcnt++;
        if (done) begin
          if (sb_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_underflow: got done, expected no transfer");
          end else begin
            e = sb_q.pop_front();
            check("err", {31'd0, err}, {31'd0, e.err});
            check("rdata", rdata, e.rdata);
            check("latency", cnt, e.lat);
            check("write_count", wcnt, e.nwr);
            if (e.chk_mem) check("mem_word", mem[e.widx], e.mword);
          end
          gap = 1;
          cnt = 0; wcnt = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] old;
    bit seen;
    logic [1:0]  rs;
    logic [31:0] ra;
    // Preload memory and reference model under reset.
    pl_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      if (i == 4)  w = 32'h8899AABB;
      if (i == 12) w = 32'h11223344;
      if (i == 16) w = 32'hCAFEF00D;
      for (int b = 0; b < 4; b++) ref_mem[i*4 + b] = w[8*b +: 8];
      @(negedge clock);
      pl_idx = i[9:0]; pl_data = w;
    end
    @(negedge clock);
    pl_en = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", dm_address, 32'd0);
    check("rst_din", dm_data_in, 32'd0);
    check("rst_we", {31'd0, dm_mem_write}, 32'd0);

    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 0);
    check("lb_sext", rdata, 32'hFFFFFF88);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 0);
    check("lbu", rdata, 32'h00000088);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 0);
    check("lw_after_sw", rdata, 32'hDEADBEEF);
    issue(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000ABCD, 0);
    check("sh_word", mem[12], 32'hABCD3344);
    issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h000000EE, 0);
    check("sb_word", mem[12], 32'hABCDEE44);
    issue(1'b0, 2'b01, 1'b0, 32'h01, 32'd0, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'd0, 0);
    check("err_rdata_hold", rdata, 32'hDEADBEEF);

    // Reset during the WRITE cycle of a byte store must suppress the write.
    old = mem[16];
    we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h42; wdata = 32'h55; req = 1'b1;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clock);
      seen = dm_mem_write;
    end
    check("rst_write_seen", {31'd0, seen}, 32'd1);
    reset = 1'b1; req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    check("rst_wr_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_done", {31'd0, done}, 32'd0);
    check("rst_wr_mem", mem[16], old);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 0);

    // Back-to-back loads with req held high.
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 1);
    issue(1'b0, 2'b00, 1'b1, 32'h30, 32'd0, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0);

    for (int t = 0; t < 300; t++) begin
      rs = 2'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) ra = (rs == 2'b00) ? ra : (rs == 2'b01) ? {ra[31:1], 1'b0} : {ra[31:2], 2'b00};
      if ($urandom_range(0, 15) == 0) ra = $urandom;
      issue(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 1)));
    end
    req = 1'b0;
    repeat (4) @(negedge clock);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store initiator placed between the CPU control unit and the 4 KB data memory. The data memory reads combinationally and writes on the clock edge. This block adds word, halfword and byte accesses, with sign or zero extension for loads. Sub-word stores use a read-modify-write of the containing word. Misaligned and out-of-range requests complete with an error and make no memory access.

## Interface
Parameters:
- MEM_BYTES_LOG2, 12: byte-address width of the data memory; an address with any bit [31:MEM_BYTES_LOG2] set is out of range.

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- req  in  1  start request, sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned or out of range
- rdata  out  32  load result, held until the next completed load
- dm_address  out  32  to memory address, always word-aligned ({a[31:2],2'b00})
- dm_data_in  out  32  to memory write data
- dm_mem_write  out  1  to memory write enable
- dm_data_out  in  32  from memory, combinational read of dm_address

## Operation
- States: IDLE, READ, WRITE, DONE. Registered state; outputs are decoded from state and latched registers.
- IDLE with req=1: latch we, size, sign_ext, addr and wdata. Then choose the next state:
  - misaligned (half with addr[0]=1, or word with addr[1:0]≠0) or out of range → DONE with err=1;
  - load → READ;
  - word store → WRITE;
  - byte or half store → READ.
- READ: dm_address = aligned latched address.
  - Load: at the edge, extract the lane and extend it into rdata. → DONE.
  - Sub-word store: at the edge, capture dm_data_out into an old-word register. → WRITE.
- WRITE: dm_mem_write=1 and dm_data_in = merged word. → DONE.
  - Word store: merged word = wdata.
  - Byte store: old word with byte lane addr[1:0] replaced by wdata[7:0].
  - Half store: old word with half lane addr[1] replaced by wdata[15:0].
- DONE: done=1. err reflects the latched error flag. → IDLE. req is ignored in DONE.
- Lane mapping is little-endian.
  - Byte k = bits [8k+7:8k], with k = addr[1:0].
  - Half 0 = [15:0], half 1 = [31:16].
- Load extension: rdata = extended lane. Sign extension replicates lane bit 7 (byte) or bit 15 (half).
- rdata is updated only by a successful load. Stores and errors leave it unchanged.
- err is cleared at the start of each accepted request.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, rdata 0, dm_address 0, dm_data_in 0, dm_mem_write 0.
- Latency, counted from the edge that samples req to the cycle in which done=1:
  - load: 2 cycles;
  - word store: 2 cycles;
  - byte or half store: 3 cycles;
  - error: 1 cycle.
- Memory timing:
  - The store commits at the edge that leaves WRITE.
  - A following load can be accepted on the edge that leaves DONE at the earliest, so it always sees the committed data.
- dm_mem_write = (state==WRITE) & ~reset. A reset asserted during WRITE suppresses the write in that cycle.
- Reset asserted in any state returns the block to IDLE at the next edge. The in-flight access is abandoned with no done pulse.
- The requester holds req until it sees done. A req still high in DONE does not restart a transfer; it is accepted again in the following IDLE cycle.

## Test plan
- Memory word 0x10 = 0x8899AABB.
  - Byte load, addr 0x13, sign_ext=1 → rdata 0xFFFFFF88, done 2 cycles after accept.
  - Same load with sign_ext=0 → rdata 0x00000088.
- Word store 0xDEADBEEF to 0x20, then word load of 0x20 → dm_mem_write high exactly 1 cycle, rdata 0xDEADBEEF.
- Word 0x30 = 0x11223344. Half store wdata 0x0000ABCD at 0x32 → memory word 0xABCD3344, done 3 cycles after accept. Then byte store 0xEE at 0x31 → 0xABCDEE44.
- Error cases, each → done 1 cycle after accept with err=1, no dm_mem_write, rdata unchanged:
  - half load at 0x01;
  - word store at 0x06;
  - word load at 0x1000 (MEM_BYTES_LOG2=12).
- Reset asserted during WRITE of a sub-word store → memory word unchanged, busy 0 and done 0 the next cycle, a new request is accepted normally.
- req held high across back-to-back loads → exactly one done per transfer and an IDLE cycle between transfers.
